// File: rtl/mem_ctl_pkg.sv
// Shared encodings for the data-memory access arbiter: decoder size controls,
// arbiter FSM states and requester source select.
package mem_ctl_pkg;

  localparam logic [1:0] CTL_BYTE = 2'd0;
  localparam logic [1:0] CTL_HALF = 2'd1;
  localparam logic [1:0] CTL_WORD = 2'd2;
  localparam logic [1:0] CTL_IDLE = 2'd3;

  localparam logic SRC_PIPE = 1'b0;
  localparam logic SRC_DBG  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_bound_check.sv
// Combinational legality check for one data-memory access: size must be
// encodable, the byte address inside the memory, and naturally aligned.
module mem_bound_check
  import mem_ctl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  output logic              valid
);

  localparam logic [ADDR_W:0] BOUND = (ADDR_W + 1)'(4 * MEM_WORDS);

  logic in_range;
  logic aligned;

  // One extra bit keeps the bound representable when it equals 2**ADDR_W.
  assign in_range = ({1'b0, addr} < BOUND);

  always_comb begin
    aligned = 1'b0;
    case (size)
      CTL_BYTE: aligned = 1'b1;
      CTL_HALF: aligned = ~addr[0];
      CTL_WORD: aligned = (addr[1:0] == 2'b00);
      default:  aligned = 1'b0;
    endcase
  end

  assign valid = in_range & aligned;

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the data-memory decoder port between the pipeline and the debug port,
// holding each access WAIT_CYCLES cycles; MEM_ARB_BOUND_CHECK_EN blocks illegal accesses.
module mem_access_arbiter
  import mem_ctl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [1:0]        pipe_size,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [1:0]        dbg_size,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [1:0]        mem_readctl,
  output logic [1:0]        mem_writectl,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_src,
  output logic              wrcheck,
  output logic              pipe_stall,
  output logic              pipe_done,
  output logic              dbg_done,
  output logic              oob_err
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  arb_state_t        state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              we_q, we_nxt;
  logic [1:0]        size_q, size_nxt;
  logic              last_q, last_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              src_nxt;
  logic [1:0]        readctl_nxt, writectl_nxt;
  logic              wrcheck_nxt, pdone_nxt, ddone_nxt, oob_nxt;

  logic              grant_src;
  logic              req_we;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic              req_valid;

  // Pipeline wins unless only debug asks or the pipeline had the last grant.
  assign grant_src = (pipe_req && (!dbg_req || last_q == SRC_DBG)) ? SRC_PIPE : SRC_DBG;
  assign req_we    = (grant_src == SRC_PIPE) ? pipe_we   : dbg_we;
  assign req_size  = (grant_src == SRC_PIPE) ? pipe_size : dbg_size;
  assign req_addr  = (grant_src == SRC_PIPE) ? pipe_addr : dbg_addr;

`ifdef MEM_ARB_BOUND_CHECK_EN
  mem_bound_check #(
    .ADDR_W   (ADDR_W),
    .MEM_WORDS(MEM_WORDS)
  ) u_bound_check (
    .size (req_size),
    .addr (req_addr),
    .valid(req_valid)
  );
`else
  assign req_valid = 1'b1;
`endif

  assign pipe_stall = pipe_req & ~pipe_done;

  always_comb begin
    state_nxt    = state_q;
    cnt_nxt      = cnt_q;
    we_nxt       = we_q;
    size_nxt     = size_q;
    last_nxt     = last_q;
    addr_nxt     = mem_addr;
    src_nxt      = mem_src;
    readctl_nxt  = CTL_IDLE;
    writectl_nxt = CTL_IDLE;
    wrcheck_nxt  = 1'b0;
    pdone_nxt    = 1'b0;
    ddone_nxt    = 1'b0;
    oob_nxt      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pipe_req || dbg_req) begin
          we_nxt   = req_we;
          size_nxt = req_size;
          addr_nxt = req_addr;
          src_nxt  = grant_src;
          last_nxt = grant_src;
          if (req_valid) begin
            state_nxt = ST_ACCESS;
            cnt_nxt   = CNT_LOAD;
            if (req_we) begin
              writectl_nxt = req_size;
              wrcheck_nxt  = 1'b1;
            end else begin
              readctl_nxt  = req_size;
            end
          end else begin
            state_nxt = ST_DONE;
            pdone_nxt = (grant_src == SRC_PIPE);
            ddone_nxt = (grant_src == SRC_DBG);
            oob_nxt   = 1'b1;
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_nxt = ST_DONE;
          pdone_nxt = (mem_src == SRC_PIPE);
          ddone_nxt = (mem_src == SRC_DBG);
        end else begin
          cnt_nxt = cnt_q - 1'b1;
          if (we_q) begin
            writectl_nxt = size_q;
            wrcheck_nxt  = 1'b1;
          end else begin
            readctl_nxt  = size_q;
          end
        end
      end

      ST_DONE: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so controls line up with ACCESS.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      size_q       <= CTL_IDLE;
      last_q       <= SRC_DBG;
      mem_addr     <= '0;
      mem_src      <= SRC_PIPE;
      mem_readctl  <= CTL_IDLE;
      mem_writectl <= CTL_IDLE;
      wrcheck      <= 1'b0;
      pipe_done    <= 1'b0;
      dbg_done     <= 1'b0;
      oob_err      <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      cnt_q        <= cnt_nxt;
      we_q         <= we_nxt;
      size_q       <= size_nxt;
      last_q       <= last_nxt;
      mem_addr     <= addr_nxt;
      mem_src      <= src_nxt;
      mem_readctl  <= readctl_nxt;
      mem_writectl <= writectl_nxt;
      wrcheck      <= wrcheck_nxt;
      pipe_done    <= pdone_nxt;
      dbg_done     <= ddone_nxt;
      oob_err      <= oob_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter: stimulus pushes expected accesses,
// a negedge monitor checks each completed access against the queue.
module tb_mem_access_arbiter;
  import mem_ctl_pkg::*;

  localparam int ADDR_W = 32;

`ifdef MEM_ARB_BOUND_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic              pipe_req, pipe_we, dbg_req, dbg_we;
  logic [1:0]        pipe_size, dbg_size;
  logic [ADDR_W-1:0] pipe_addr, dbg_addr;
  logic [1:0]        mem_readctl, mem_writectl;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_src, wrcheck, pipe_stall, pipe_done, dbg_done, oob_err;

  always #5 clk = ~clk;

  mem_access_arbiter #(.ADDR_W(ADDR_W), .MEM_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rstn(rstn),
    .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_size(pipe_size), .pipe_addr(pipe_addr),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size), .dbg_addr(dbg_addr),
    .mem_readctl(mem_readctl), .mem_writectl(mem_writectl), .mem_addr(mem_addr),
    .mem_src(mem_src), .wrcheck(wrcheck), .pipe_stall(pipe_stall),
    .pipe_done(pipe_done), .dbg_done(dbg_done), .oob_err(oob_err)
  );

  typedef struct {
    logic        src;
    logic        oob;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        wrc;
    logic [31:0] addr;
    int          ncyc;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic src, input logic oob, input logic [1:0] rd,
                              input logic [1:0] wr, input logic wrc, input logic [31:0] addr,
                              input int ncyc);
    exp_t e;
    e.src = src; e.oob = oob; e.rd = rd; e.wr = wr; e.wrc = wrc; e.addr = addr; e.ncyc = ncyc;
    return e;
  endfunction

  // Monitor: accumulate what the decoder saw, compare when a done pulses.
  int         ncyc_m;
  logic [1:0] rd_m, wr_m;
  logic       wrc_m;
  exp_t       em;

  always @(negedge clk) begin
    if (!rstn) begin
      ncyc_m = 0; rd_m = CTL_IDLE; wr_m = CTL_IDLE; wrc_m = 1'b0;
    end else begin
      if (mem_readctl != CTL_IDLE || mem_writectl != CTL_IDLE) ncyc_m++;
      if (mem_readctl != CTL_IDLE) rd_m = mem_readctl;
      if (mem_writectl != CTL_IDLE) wr_m = mem_writectl;
      if (wrcheck) wrc_m = 1'b1;
      if (pipe_done || dbg_done) begin
        if (expq.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_unexpected_done: pipe_done=%0b dbg_done=%0b with empty queue", pipe_done, dbg_done);
        end else begin
          em = expq.pop_front();
          chk("sb_src", {pipe_done, dbg_done}, em.src ? 2'b01 : 2'b10);
          chk("sb_oob", oob_err, em.oob);
          chk("sb_readctl", rd_m, em.rd);
          chk("sb_writectl", wr_m, em.wr);
          chk("sb_wrcheck", wrc_m, em.wrc);
          chk("sb_addr", mem_addr, em.addr);
          chk("sb_ctl_cycles", ncyc_m, em.ncyc);
        end
        ncyc_m = 0; rd_m = CTL_IDLE; wr_m = CTL_IDLE; wrc_m = 1'b0;
      end
    end
  end

  task automatic issue(input logic src, input logic we, input logic [1:0] size, input logic [31:0] addr);
    @(posedge clk); #1;
    if (src == SRC_PIPE) begin
      pipe_req = 1'b1; pipe_we = we; pipe_size = size; pipe_addr = addr;
    end else begin
      dbg_req = 1'b1; dbg_we = we; dbg_size = size; dbg_addr = addr;
    end
  endtask

  // Cycle index 0 is the cycle the request is first visible; bounded wait.
  task automatic wait_done(input logic src, input string name, output int lat);
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if ((src == SRC_PIPE) ? pipe_done : dbg_done) lat = i;
    end
    if (lat < 0) begin
      tests++; fails++;
      $display("FAIL %s_timeout: no done within 20 cycles, expected one", name);
    end
    @(posedge clk); #1;
    if (src == SRC_PIPE) pipe_req = 1'b0; else dbg_req = 1'b0;
  endtask

  task automatic access(input string name, input logic src, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input exp_t e, input int exp_lat);
    int lat;
    issue(src, we, size, addr);
    expq.push_back(e);
    wait_done(src, name, lat);
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    rstn = 1'b0;
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_size = CTL_WORD; pipe_addr = 32'h40;
    dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_size  = CTL_BYTE; dbg_addr  = 32'h41;
    #12;
    chk("rst_readctl", mem_readctl, 2'd3);
    chk("rst_writectl", mem_writectl, 2'd3);
    chk("rst_wrcheck", wrcheck, 1'b0);
    chk("rst_pipe_done", pipe_done, 1'b0);
    chk("rst_dbg_done", dbg_done, 1'b0);
    chk("rst_oob", oob_err, 1'b0);
    chk("rst_src", mem_src, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);

    // Both requests pending out of reset: pipeline first, debug right after.
    expq.push_back(mk(SRC_PIPE, 1'b0, CTL_WORD, CTL_IDLE, 1'b0, 32'h40, 2));
    expq.push_back(mk(SRC_DBG,  1'b0, CTL_BYTE, CTL_IDLE, 1'b0, 32'h41, 2));
    @(posedge clk); #1; rstn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1) chk("tie_first_src", mem_src, SRC_PIPE);
      if (c == 2) chk("tie_first_readctl", mem_readctl, CTL_WORD);
      if (c == 3) chk("tie_pipe_done", pipe_done, 1'b1);
      if (c == 4) chk("tie_gap_readctl", mem_readctl, CTL_IDLE);
      if (c == 5) chk("tie_second_src", mem_src, SRC_DBG);
      if (c == 5) chk("tie_second_readctl", mem_readctl, CTL_BYTE);
      if (c == 7) chk("tie_dbg_done", dbg_done, 1'b1);
      if (c == 3) begin @(posedge clk); #1; pipe_req = 1'b0; end
      if (c == 7) begin @(posedge clk); #1; dbg_req = 1'b0; end
    end

    // Pipeline word load with cycle-exact checks.
    issue(SRC_PIPE, 1'b0, CTL_WORD, 32'h10);
    expq.push_back(mk(SRC_PIPE, 1'b0, CTL_WORD, CTL_IDLE, 1'b0, 32'h10, 2));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("ld_c%0d_stall", c), pipe_stall, (c < 3) ? 1'b1 : 1'b0);
      chk($sformatf("ld_c%0d_readctl", c), mem_readctl, (c == 1 || c == 2) ? CTL_WORD : CTL_IDLE);
      chk($sformatf("ld_c%0d_done", c), pipe_done, (c == 3) ? 1'b1 : 1'b0);
    end
    @(posedge clk); #1; pipe_req = 1'b0;

    access("blk_misaligned_st", SRC_DBG, 1'b1, CTL_WORD, 32'h1002,
           BC ? mk(SRC_DBG, 1'b1, CTL_IDLE, CTL_IDLE, 1'b0, 32'h1002, 0)
              : mk(SRC_DBG, 1'b0, CTL_IDLE, CTL_WORD, 1'b1, 32'h1002, 2), BC ? 1 : 3);
    access("blk_bound_st", SRC_DBG, 1'b1, CTL_WORD, 32'h1000,
           BC ? mk(SRC_DBG, 1'b1, CTL_IDLE, CTL_IDLE, 1'b0, 32'h1000, 0)
              : mk(SRC_DBG, 1'b0, CTL_IDLE, CTL_WORD, 1'b1, 32'h1000, 2), BC ? 1 : 3);
    access("half_st", SRC_DBG, 1'b1, CTL_HALF, 32'h6,
           mk(SRC_DBG, 1'b0, CTL_IDLE, CTL_HALF, 1'b1, 32'h6, 2), 3);
    access("blk_half_ld", SRC_PIPE, 1'b0, CTL_HALF, 32'h7,
           BC ? mk(SRC_PIPE, 1'b1, CTL_IDLE, CTL_IDLE, 1'b0, 32'h7, 0)
              : mk(SRC_PIPE, 1'b0, CTL_HALF, CTL_IDLE, 1'b0, 32'h7, 2), BC ? 1 : 3);
    access("byte_ld_top", SRC_PIPE, 1'b0, CTL_BYTE, 32'hFFF,
           mk(SRC_PIPE, 1'b0, CTL_BYTE, CTL_IDLE, 1'b0, 32'hFFF, 2), 3);
    access("size3_ld", SRC_PIPE, 1'b0, CTL_IDLE, 32'h8,
           mk(SRC_PIPE, BC, CTL_IDLE, CTL_IDLE, 1'b0, 32'h8, 0), BC ? 1 : 3);
    access("word_ld_top", SRC_DBG, 1'b0, CTL_WORD, 32'hFFC,
           mk(SRC_DBG, 1'b0, CTL_WORD, CTL_IDLE, 1'b0, 32'hFFC, 2), 3);

    // Reset in cycle 1 of a store; the held request is re-granted afterwards.
    begin
      int lat;
      issue(SRC_PIPE, 1'b1, CTL_WORD, 32'h20);
      @(negedge clk);
      @(negedge clk);
      chk("rmid_writectl_before", mem_writectl, CTL_WORD);
      #1; rstn = 1'b0; #1;
      chk("rmid_writectl", mem_writectl, CTL_IDLE);
      chk("rmid_readctl", mem_readctl, CTL_IDLE);
      chk("rmid_wrcheck", wrcheck, 1'b0);
      @(negedge clk);
      chk("rmid_no_done", pipe_done, 1'b0);
      @(posedge clk); #1; rstn = 1'b1;
      expq.push_back(mk(SRC_PIPE, 1'b0, CTL_IDLE, CTL_WORD, 1'b1, 32'h20, 2));
      wait_done(SRC_PIPE, "rmid_regrant", lat);
      chk("rmid_regrant_latency", lat, 3);
    end

    repeat (3) @(posedge clk);
    chk("queue_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
